// File: rtl/c7m_pkg.sv
// Purpose : shared constants, types and a phase helper for the C7M phase tracker.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   PHASES_PER_C7M / PHASE_HALF : clk cycles per C7M period, and the mid-period phase.
//   phase_t / m68k_state_t      : 3-bit phase (0..5) and 68000 half-clock state (S0..S7).
//   phase_step()                : free-running 0..5 phase increment with wrap.
package c7m_pkg;

    localparam int PHASES_PER_C7M = 6;
    localparam int PHASE_HALF     = 3;

    typedef logic [2:0] phase_t;
    typedef logic [2:0] m68k_state_t;

    localparam phase_t PHASE_LAST = phase_t'(PHASES_PER_C7M - 1);
    localparam phase_t PHASE_MID  = phase_t'(PHASE_HALF);

    // Advance the phase by one clk, wrapping after the last phase of the period.
    function automatic phase_t phase_step(input phase_t p);
        phase_t r;
        if (p == PHASE_LAST) begin
            r = '0;
        end else begin
            r = p + phase_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Purpose : multi-flop synchroniser for an asynchronous single-bit input.
// Latency : SYNC_STAGES clk edges from d to q.
// Backpressure: none; free-running, samples every clk.
//
// Ports:
//   clk    in  sampling clock
//   reset  in  synchronous active-high, clears the chain to 0
//   d      in  asynchronous input
//   q      out synchronised output (last flop of the chain)
// Generic: reusable for any asynchronous Amiga bus input (SYNC_STAGES >= 2).
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/c7m_phase_tracker.sv
// Purpose : tracks the Amiga C7M bus clock from a 6x clk; phase, edge strobes, lock, 68000 S-state.
// Latency : c7m_in edge to rise_stb/fall_stb = SYNC_STAGES+1 clk edges (+1 with C7M_FILTER_EN).
// Backpressure: none; free-running, every output is a registered per-clk status.
//
// Ports:
//   clk         in   6x C7M clock from the PLL
//   reset       in   synchronous active-high; held while the PLL is unlocked
//   c7m_in      in   raw asynchronous C7M
//   state_sync  in   request to realign m68k_state to 0 at the next phase-0 half strobe
//   phase       out  clk cycles since the last C7M rise, 0..5 (flywheels through missing edges)
//   rise_stb    out  1-clk pulse on a detected C7M rise (phase==0 in the same cycle)
//   fall_stb    out  1-clk pulse on a detected C7M fall (informational)
//   half_stb    out  1-clk pulse at phase 0 and phase 3 while locked
//   m68k_state  out  68000 half-clock state S0..S7
//   locked      out  C7M period has been stable at 6 clk for LOCK_PERIODS periods
//   err_cnt     out  saturating count of period errors
// Build option: define C7M_FILTER_EN to insert a 3-tap majority glitch filter after the synchroniser.
module c7m_phase_tracker
    import c7m_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_PERIODS = 4,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c7m_in,
    input  logic             state_sync,
    output logic [2:0]       phase,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             half_stb,
    output logic [2:0]       m68k_state,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_PERIODS);

    // ------------------------------------------------------------------
    // Synchroniser, optional glitch filter, edge detect
    // ------------------------------------------------------------------
    logic c7m_sync;
    logic c7m_lvl;
    logic c7m_prev;
    logic rise;
    logic fall;

    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (c7m_in),
        .q     (c7m_sync)
    );

`ifdef C7M_FILTER_EN
    // Majority of the current and two previous synchronised samples: a
    // level must persist for two clk to pass, so a 1-clk glitch never
    // reaches the edge detector. Costs one clk of edge latency.
    logic [1:0] taps;

    always_ff @(posedge clk) begin
        if (reset) begin
            taps <= '0;
        end else begin
            taps <= {taps[0], c7m_sync};
        end
    end

    assign c7m_lvl = (c7m_sync & taps[0]) | (c7m_sync & taps[1]) | (taps[0] & taps[1]);
`else
    assign c7m_lvl = c7m_sync;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            c7m_prev <= 1'b0;
        end else begin
            c7m_prev <= c7m_lvl;
        end
    end

    assign rise = c7m_lvl & ~c7m_prev;
    assign fall = ~c7m_lvl & c7m_prev;

    // ------------------------------------------------------------------
    // Phase, period check, lock and half-state next-state logic
    // ------------------------------------------------------------------
    logic             acq;       // waiting for the first rise after reset
    logic [3:0]       lock_cnt;  // consecutive good periods, saturating at LOCK_TARGET
    logic             pend;      // state_sync seen, waiting for a phase-0 half strobe

    phase_t           phase_nxt;
    logic             wrap;
    logic             good_evt;
    logic             err_evt;
    logic [3:0]       lock_cnt_nxt;
    logic             locked_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;
    logic             half_nxt;
    logic             consume;
    m68k_state_t      state_nxt;
    logic             pend_nxt;
    logic             acq_nxt;

    always_comb begin
        phase_nxt    = phase_step(phase);
        wrap         = 1'b0;
        good_evt     = 1'b0;
        err_evt      = 1'b0;
        lock_cnt_nxt = lock_cnt;
        err_cnt_nxt  = err_cnt;
        state_nxt    = m68k_state;
        consume      = 1'b0;
        acq_nxt      = acq;

        // A rise always re-anchors the phase; otherwise the counter
        // flywheels so downstream timing survives a missing edge.
        if (rise) begin
            phase_nxt = '0;
            acq_nxt   = 1'b0;
        end else begin
            wrap = (phase == PHASE_LAST);
        end

        // The first rise after reset only anchors the phase. After that a
        // rise must land exactly one period after the previous anchor, and a
        // wrap without a rise means the edge went missing.
        if (!acq) begin
            good_evt = rise & (phase == PHASE_LAST);
            err_evt  = (rise & (phase != PHASE_LAST)) | wrap;
        end

        if (err_evt) begin
            lock_cnt_nxt = '0;
            if (!(&err_cnt)) begin
                err_cnt_nxt = err_cnt + ERR_W'(1);
            end
        end else if (good_evt && (lock_cnt != LOCK_TARGET)) begin
            lock_cnt_nxt = lock_cnt + 4'd1;
        end

        // Lock follows the counter by one clk and drops in the same clk as
        // the error that breaks it.
        locked_nxt = ~err_evt & (lock_cnt == LOCK_TARGET);

        half_nxt = locked_nxt & ((phase_nxt == '0) | (phase_nxt == PHASE_MID));

        // A pending realign is only honoured on the phase-0 half strobe so
        // S0 always starts on a C7M rise.
        if (!locked_nxt) begin
            state_nxt = '0;
        end else if (half_nxt) begin
            if ((phase_nxt == '0) && pend) begin
                state_nxt = '0;
                consume   = 1'b1;
            end else begin
                state_nxt = m68k_state + m68k_state_t'(1);
            end
        end

        // Requests arriving while unlocked are dropped; one arriving in the
        // same clk as a realign is absorbed by it.
        pend_nxt = locked_nxt & ~consume & (pend | (state_sync & locked));
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= '0;
            rise_stb   <= 1'b0;
            fall_stb   <= 1'b0;
            half_stb   <= 1'b0;
            m68k_state <= '0;
            locked     <= 1'b0;
            err_cnt    <= '0;
            lock_cnt   <= '0;
            pend       <= 1'b0;
            acq        <= 1'b1;
        end else begin
            phase      <= phase_nxt;
            rise_stb   <= rise;
            fall_stb   <= fall;
            half_stb   <= half_nxt;
            m68k_state <= state_nxt;
            locked     <= locked_nxt;
            err_cnt    <= err_cnt_nxt;
            lock_cnt   <= lock_cnt_nxt;
            pend       <= pend_nxt;
            acq        <= acq_nxt;
        end
    end

endmodule

// File: tb/tb_c7m_phase_tracker.sv
// Purpose : self-checking bench for c7m_phase_tracker (segment table, corner sequences, random C7M).
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_c7m_phase_tracker;

    localparam int SYNC  = 2;
    localparam int LOCKP = 4;
    localparam int ERRW  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            c7m_in;
    logic            state_sync;
    logic [2:0]      phase;
    logic            rise_stb;
    logic            fall_stb;
    logic            half_stb;
    logic [2:0]      m68k_state;
    logic            locked;
    logic [ERRW-1:0] err_cnt;

    always #5 clk = ~clk;

    c7m_phase_tracker #(
        .SYNC_STAGES  (SYNC),
        .LOCK_PERIODS (LOCKP),
        .ERR_W        (ERRW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .c7m_in     (c7m_in),
        .state_sync (state_sync),
        .phase      (phase),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb),
        .half_stb   (half_stb),
        .m68k_state (m68k_state),
        .locked     (locked),
        .err_cnt    (err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural reference model ----------------
    // hist[0] is the c7m_in sample taken at the latest clk edge.
    bit hist [0:7];
    int m_age;      // clk cycles since the last rise (or reset); phase = age mod 6
    bit m_acq;
    int m_good;     // consecutive good periods (unbounded)
    int m_err;
    bit m_locked, m_rise, m_fall, m_half, m_pend;
    int m_state;

    function automatic bit maj3(input bit a, input bit b, input bit c);
        return (a + b + c) >= 2;
    endfunction

    // Level presented to the edge detector 'back' clk ago.
    function automatic bit level(input int back);
`ifdef C7M_FILTER_EN
        return maj3(hist[SYNC+back-1], hist[SYNC+back], hist[SYNC+back+1]);
`else
        return hist[SYNC+back-1];
`endif
    endfunction

    task automatic model_step(input bit r, input bit c, input bit ss);
        bit lv1, lv2, err, good, consumed, locked_old;
        int ph_old;
        if (r) begin
            for (int i = 0; i < 8; i++) hist[i] = 1'b0;
            m_age = 0; m_acq = 1'b1; m_good = 0; m_err = 0;
            m_locked = 0; m_rise = 0; m_fall = 0; m_half = 0; m_state = 0; m_pend = 0;
            return;
        end
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = c;
        lv1 = level(1);
        lv2 = level(2);
        m_rise = lv1 & ~lv2;
        m_fall = ~lv1 & lv2;
        ph_old = m_age % 6;
        err = 0; good = 0;
        if (m_rise) begin
            if (m_acq) m_acq = 0;
            else if (ph_old == 5) good = 1;
            else err = 1;
            m_age = 0;
        end else begin
            m_age++;
            if ((m_age % 6 == 0) && !m_acq) err = 1;
        end
        locked_old = m_locked;
        if (err) begin
            m_err    = (m_err < 255) ? m_err + 1 : 255;
            m_locked = 0;
            m_good   = 0;
        end else begin
            m_locked = (m_good >= LOCKP);
            if (good) m_good++;
        end
        m_half = m_locked && ((m_age % 6 == 0) || (m_age % 6 == 3));
        consumed = 0;
        if (!m_locked) begin
            m_state = 0;
        end else if (m_half) begin
            if ((m_age % 6 == 0) && m_pend) begin
                m_state = 0;
                consumed = 1;
            end else begin
                m_state = (m_state + 1) % 8;
            end
        end
        m_pend = m_locked && !consumed && (m_pend || (ss && locked_old));
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_cycle();
        logic [2:0] e_ph, e_st;
        logic [ERRW-1:0] e_err;
        e_ph  = 3'(m_age % 6);
        e_st  = 3'(m_state);
        e_err = ERRW'(m_err);
        n_cmp++;
        if ({phase, rise_stb, fall_stb, half_stb, m68k_state, locked, err_cnt} !==
            {e_ph, m_rise, m_fall, m_half, e_st, m_locked, e_err}) begin
            n_bad++;
            $display("FAIL model t=%0t got ph=%0d r=%b f=%b h=%b st=%0d lk=%b err=%0d want ph=%0d r=%b f=%b h=%b st=%0d lk=%b err=%0d",
                     $time, phase, rise_stb, fall_stb, half_stb, m68k_state, locked, err_cnt,
                     e_ph, m_rise, m_fall, m_half, e_st, m_locked, e_err);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // Apply one clk worth of inputs, step the model, compare at the falling edge.
    task automatic tick(input bit c, input bit r, input bit ss);
        c7m_in = c; reset = r; state_sync = ss;
        @(posedge clk);
        model_step(r, c, ss);
        @(negedge clk);
        check_cycle();
    endtask

    int wpos = 0;   // position in a clean 3-high/3-low C7M waveform
    task automatic clean(input bit ss);
        tick(wpos < 3, 1'b0, ss);
        wpos = (wpos + 1) % 6;
    endtask

    typedef struct {
        int h;
        int l;
        int reps;
        bit exp_locked;
        int exp_err;
    } seg_t;

    seg_t segs [10];

    initial begin
        bit found;
        c7m_in = 0; reset = 1; state_sync = 0;
        @(negedge clk);

        // Segments applied back to back after reset; expectations are cumulative.
        segs[0] = '{3, 3,    1, 1'b0, 0};    // acquisition rise only
        segs[1] = '{3, 3,    3, 1'b0, 0};    // three good periods
        segs[2] = '{3, 3,    1, 1'b1, 0};    // fourth good period -> locked
        segs[3] = '{3, 2,    1, 1'b1, 0};    // 5-clk period; its early rise lands in the next segment
        segs[4] = '{3, 3,    4, 1'b0, 1};    // early rise error, then 3 good
        segs[5] = '{3, 3,    1, 1'b1, 1};    // relocked after 4 good
        segs[6] = '{0, 24,   1, 1'b0, 5};    // C7M stuck low: 4 missed-edge wraps
        segs[7] = '{3, 3,    1, 1'b0, 5};    // rise exactly at phase 5 beats the wrap: good
        segs[8] = '{3, 3,    3, 1'b1, 5};    // relocked
        segs[9] = '{0, 1600, 1, 1'b0, 255};  // err_cnt saturates

        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
        chk("reset_outputs", {phase, rise_stb, fall_stb, half_stb, m68k_state, locked, err_cnt}, 0);

        foreach (segs[s]) begin
            for (int r = 0; r < segs[s].reps; r++) begin
                for (int i = 0; i < segs[s].h; i++) tick(1'b1, 1'b0, 1'b0);
                for (int i = 0; i < segs[s].l; i++) tick(1'b0, 1'b0, 1'b0);
            end
            chk($sformatf("seg%0d_locked", s), locked, segs[s].exp_locked);
            chk($sformatf("seg%0d_err", s), err_cnt, segs[s].exp_err);
        end

        // state_sync realign: pulse at phase 2 with state 4
        tick(1'b0, 1'b1, 1'b0);
        wpos = 0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            clean(1'b0);
            if (m_locked && (m_age % 6 == 2) && (m_state == 4)) found = 1;
        end
        chk("sync_found_phase2_state4", found, 1);
        clean(1'b1);
        chk("sync_phase3", phase, 3);
        chk("sync_state5", m68k_state, 5);
        for (int i = 0; i < 3; i++) clean(1'b0);
        chk("sync_phase0", phase, 0);
        chk("sync_state0", m68k_state, 0);
        chk("sync_half", half_stb, 1);
        for (int i = 0; i < 3; i++) clean(1'b0);
        chk("sync_state1", m68k_state, 1);

        // One-cycle reset mid-lock, applied during the low half of C7M
        for (int i = 0; i < 12 && wpos != 4; i++) clean(1'b0);
        tick(1'b0, 1'b1, 1'b0);
        wpos = 5;
        chk("midreset_outputs", {phase, rise_stb, fall_stb, half_stb, m68k_state, locked, err_cnt}, 0);
        for (int i = 0; i < 20; i++) clean(1'b0);
        chk("midreset_no_err", err_cnt, 0);
        chk("midreset_not_locked", locked, 0);

        // Single-clk glitch during the low half while locked
        for (int i = 0; i < 40; i++) clean(1'b0);
        chk("glitch_pre_locked", locked, 1);
        for (int i = 0; i < 12 && wpos != 4; i++) clean(1'b0);
        tick(1'b1, 1'b0, 1'b0);
        wpos = 5;
        for (int i = 0; i < 12; i++) clean(1'b0);
`ifdef C7M_FILTER_EN
        chk("glitch_err", err_cnt, 0);
        chk("glitch_locked", locked, 1);
`else
        chk("glitch_err", err_cnt, 2);
        chk("glitch_locked", locked, 0);
`endif

        // Randomised C7M with jitter, glitches, realign requests and rare resets
        for (int n = 0; n < 4000; ) begin
            int sel, h, l;
            sel = $urandom_range(0, 19);
            if (sel < 14)      begin h = 3; l = 3; end
            else if (sel < 17) begin h = $urandom_range(1, 4); l = $urandom_range(1, 4); end
            else if (sel < 19) begin h = 0; l = $urandom_range(1, 10); end
            else               begin h = 1; l = 1; end
            for (int i = 0; i < h + l; i++) begin
                tick(i < h, $urandom_range(0, 599) == 0, $urandom_range(0, 9) == 0);
                n++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
